mux4_rr_arbiter: RTL and testbench
==================================

// Module: mux4_rr_arbiter
// PURPOSE
// - Round-robin arbiter that shares one mux4 (1-bit, 4->1) between four requesters.
// - Registers a one-hot grant and the matching 2-bit select, and drives them into an internal mux4 instance.
// - Bounds each grant to a burst of at most BURST_MAX cycles, so one requester cannot starve the others.
// - Sits between requester logic and the shared 1-bit output path. z is valid whenever z_valid=1.
// PARAMETERS
// - BURST_MAX  4  max consecutive cycles per grant; legal range >=1
// - CNT_W (localparam) = $clog2(BURST_MAX+1)  width of the burst counter
// PORTS
// - clk      in   1  single clock, rising edge
// - rst_n    in   1  asynchronous, active-low reset
// - req      in   4  req[i]=1: requester i wants the mux
// - d        in   4  d[i] = data bit of requester i, fed to mux4 input d<i>
// - lock     in   1  only with MUX4_ARB_LOCK_EN: owner asks to extend its burst
// - gnt      out  4  registered one-hot grant; all zero when idle
// - sel      out  2  registered index of the owner; drives mux4 sel
// - z_valid  out  1  = |gnt
// - z        out  1  mux4 output = d[sel]; combinational from sel and d
// BEHAVIOUR
// - Reset (async; asserts immediately, including mid-burst):
//   - state=IDLE, gnt=0, sel=0, z_valid=0, cnt=0, last=3 (so req0 has first priority).
// - Arbitration function pick(start): first i with req[i]=1, scanning start, start+1, ... mod 4.
// - FSM states: IDLE, GRANT. All decisions are taken at the rising edge.
// - IDLE:
//   - No request: stay in IDLE.
//   - Any request: o=pick(last+1); gnt<=1<<o, sel<=o, cnt<=1, state<=GRANT.
//   - Latency from req to gnt is 1 cycle.
// - GRANT, owner o=sel:
//   - Hold while req[o]=1 and cnt<BURST_MAX; cnt<=cnt+1 each cycle.
//   - Release when req[o]=0 or cnt==BURST_MAX; on release last<=o.
//   - In the same edge: if any req, re-grant pick(o+1) with cnt<=1. No idle bubble between grants.
//   - Otherwise: gnt<=0, state<=IDLE.
// - Burst-end corner cases:
//   - Owner is the sole requester at burst end: it is re-granted (cnt<=1) with no gap.
//   - A newly raised request is considered only at a release or IDLE edge.
// - sel holds its last value while idle. z is still d[sel], but only meaningful when z_valid=1.
// - Invariants:
//   - gnt is always one-hot or zero.
//   - gnt[sel]=1 whenever z_valid=1.
//   - cnt never exceeds BURST_MAX.
// CONFIGURATION
// - Macro MUX4_ARB_LOCK_EN.
// - Defined:
//   - lock port exists.
//   - In GRANT with lock=1 and req[o]=1, the cnt==BURST_MAX release is suppressed; cnt saturates at BURST_MAX.
//   - When lock falls with cnt==BURST_MAX, release happens at the next edge.
//   - req[o]=0 still releases regardless of lock.
// - Undefined: no lock port; behaviour exactly as in BEHAVIOUR.
// TESTING (BURST_MAX=4 unless noted)
// - Reset: hold rst_n=0 with req=1111 -> gnt=0000, sel=0, z_valid=0 throughout.
// - Single requester, req=0001 held from cycle 0:
//   - gnt=0001 from edge 1, z=d[0].
//   - After 4 cycles it is re-granted with no gap; z_valid never drops.
// - Full contention, req=1111 held:
//   - gnt = 0001 x4, 0010 x4, 0100 x4, 1000 x4, 0001 ...
//   - sel=0,1,2,3 accordingly; z tracks d[sel].
// - Early release: req=0101, owner 0 drops req after 2 grant cycles -> next edge gnt=0100, sel=2, cnt=1.
// - Async reset mid-burst: rst_n low between edges -> gnt=0 immediately. After release with req=1111 -> gnt=0001.
// - Lock (MUX4_ARB_LOCK_EN), req=0011, lock=1 for 10 cycles:
//   - gnt=0001 for all 10 cycles.
//   - lock=0 -> next edge gnt=0010.

Source files
------------

// File: rtl/mux4_rr_arbiter_if.sv
// Handshake/data bundle between four requesters and the shared mux4 arbiter.
// The lock signal exists only when MUX4_ARB_LOCK_EN is defined.
interface mux4_rr_arbiter_if;
  logic [3:0] req;
  logic [3:0] d;
`ifdef MUX4_ARB_LOCK_EN
  logic       lock;
`endif
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       z_valid;
  logic       z;

`ifdef MUX4_ARB_LOCK_EN
  modport master (output req, output d, output lock,
                  input gnt, input sel, input z_valid, input z);
  modport slave  (input req, input d, input lock,
                  output gnt, output sel, output z_valid, output z);
`else
  modport master (output req, output d,
                  input gnt, input sel, input z_valid, input z);
  modport slave  (input req, input d,
                  output gnt, output sel, output z_valid, output z);
`endif
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 1-bit 4->1 mux between four requesters, with bursts
// capped at BURST_MAX cycles. Optional burst extension via lock under MUX4_ARB_LOCK_EN.
module mux4 (
  input  logic [3:0] d,
  input  logic [1:0] sel,
  output logic       z
);
  // Shared 4->1 data path.
  always_comb begin
    case (sel)
      2'd0:    z = d[0];
      2'd1:    z = d[1];
      2'd2:    z = d[2];
      2'd3:    z = d[3];
      default: z = 1'b0;
    endcase
  end
endmodule

module mux4_rr_arbiter #(
  parameter int BURST_MAX = 4
) (
  input logic               clk,
  input logic               rst_n,
  mux4_rr_arbiter_if.slave  bus
);
  localparam int CNT_W = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t           state_r;
  logic [3:0]       gnt_r;
  logic [1:0]       sel_r;
  logic [1:0]       last_r;
  logic [CNT_W-1:0] cnt_r;

  logic             any_req_s;
  logic             release_s;
  logic             lock_s;
  logic [1:0]       start_s;
  logic [1:0]       pick_s;
  logic [3:0]       pick_oh_s;

  // First requester at or after start, wrapping mod 4.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] start);
    logic [1:0] idx;
    logic       found;
    pick  = start;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = start + 2'(k);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
  endfunction

`ifdef MUX4_ARB_LOCK_EN
  assign lock_s = bus.lock;
`else
  assign lock_s = 1'b0;
`endif

  // Next-owner selection and release decision for the coming edge.
  always_comb begin
    any_req_s = |bus.req;
    if (state_r == GRANT) begin
      start_s   = sel_r + 2'd1;
      release_s = !bus.req[sel_r] || ((cnt_r == CNT_MAX) && !lock_s);
    end else begin
      start_s   = last_r + 2'd1;
      release_s = 1'b0;
    end
    pick_s    = pick(bus.req, start_s);
    pick_oh_s = 4'b0001 << pick_s;
  end

  // Arbiter FSM with registered grant, select and burst counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      gnt_r   <= 4'b0000;
      sel_r   <= 2'd0;
      last_r  <= 2'd3;
      cnt_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            gnt_r   <= pick_oh_s;
            sel_r   <= pick_s;
            cnt_r   <= CNT_ONE;
            state_r <= GRANT;
          end else begin
            state_r <= IDLE;
          end
        end
        GRANT: begin
          if (release_s) begin
            last_r <= sel_r;
            if (any_req_s) begin
              gnt_r <= pick_oh_s;
              sel_r <= pick_s;
              cnt_r <= CNT_ONE;
            end else begin
              gnt_r   <= 4'b0000;
              cnt_r   <= '0;
              state_r <= IDLE;
            end
          end else if (cnt_r < CNT_MAX) begin
            cnt_r <= cnt_r + CNT_ONE;
          end else begin
            // Locked past the cap: counter saturates until lock drops.
            cnt_r <= cnt_r;
          end
        end
        default: begin
          state_r <= IDLE;
          gnt_r   <= 4'b0000;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  assign bus.gnt     = gnt_r;
  assign bus.sel     = sel_r;
  assign bus.z_valid = |gnt_r;

  mux4 u_mux4 (
    .d   (bus.d),
    .sel (sel_r),
    .z   (bus.z)
  );
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Table-driven, scoreboard-checked bench for mux4_rr_arbiter (BURST_MAX=4).
module tb_mux4_rr_arbiter;
  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  mux4_rr_arbiter_if bus ();

  mux4_rr_arbiter #(.BURST_MAX(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       zv;
  } vec_t;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       zv;
    logic       z;
    string      name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic void add(input logic rst, input logic [3:0] req,
                              input logic [3:0] gnt, input logic [1:0] sel, input logic zv);
    vec_t v;
    v.rst = rst; v.req = req; v.gnt = gnt; v.sel = sel; v.zv = zv;
    vecs.push_back(v);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    bus.req = 4'b0000;
    #2;
    rst_n   = 1'b1;
  endtask

  task automatic step(input logic [3:0] req, input logic [3:0] eg, input logic [1:0] es,
                      input logic ezv, input string name);
    logic [3:0] dv;
    exp_t       e;
    @(negedge clk);
    dv      = 4'($urandom);
    bus.req = req;
    bus.d   = dv;
    e.gnt = eg; e.sel = es; e.zv = ezv; e.z = dv[es]; e.name = name;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s.scoreboard: got empty queue expected one entry", name);
    end else begin
      e = sb.pop_front();
      chk({e.name, ".gnt"}, bus.gnt, e.gnt);
      chk({e.name, ".sel"}, {2'b00, bus.sel}, {2'b00, e.sel});
      chk({e.name, ".z_valid"}, {3'b000, bus.z_valid}, {3'b000, e.zv});
      chk({e.name, ".z"}, {3'b000, bus.z}, {3'b000, e.z});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    rst_n   = 1'b0;
    bus.req = 4'b1111;
    bus.d   = 4'b1010;
`ifdef MUX4_ARB_LOCK_EN
    bus.lock = 1'b0;
`endif
    // Reset held with all requests active.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst.gnt", bus.gnt, 4'b0000);
      chk("rst.sel", {2'b00, bus.sel}, 4'd0);
      chk("rst.z_valid", {3'b000, bus.z_valid}, 4'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Single requester: re-granted every 4 cycles with no gap.
    for (int k = 0; k < 10; k++) add(k == 0, 4'b0001, 4'b0001, 2'd0, 1'b1);
    // Full contention: four-cycle bursts rotating 0,1,2,3,0.
    for (int k = 0; k < 20; k++)
      add(k == 0, 4'b1111, 4'b0001 << ((k / 4) % 4), 2'((k / 4) % 4), 1'b1);
    // Early release, idle with sel held, then rotation resumes after last owner.
    add(1'b1, 4'b0101, 4'b0001, 2'd0, 1'b1);
    add(1'b0, 4'b0101, 4'b0001, 2'd0, 1'b1);
    add(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1);
    add(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1);
    add(1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0);
    add(1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0);
    add(1'b0, 4'b1001, 4'b1000, 2'd3, 1'b1);
    // A request raised mid-burst waits for the burst to end.
    add(1'b1, 4'b0001, 4'b0001, 2'd0, 1'b1);
    add(1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1);
    add(1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1);
    add(1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1);
    add(1'b0, 4'b0011, 4'b0010, 2'd1, 1'b1);
    add(1'b0, 4'b0011, 4'b0010, 2'd1, 1'b1);

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      step(vecs[i].req, vecs[i].gnt, vecs[i].sel, vecs[i].zv, $sformatf("vec%0d", i));
    end

    // Asynchronous reset between edges, mid-burst.
    do_reset();
    step(4'b1111, 4'b0001, 2'd0, 1'b1, "amr0");
    step(4'b1111, 4'b0001, 2'd0, 1'b1, "amr1");
    #2;
    rst_n   = 1'b0;
    bus.req = 4'b0000;
    #1;
    chk("amr_async.gnt", bus.gnt, 4'b0000);
    chk("amr_async.sel", {2'b00, bus.sel}, 4'd0);
    chk("amr_async.z_valid", {3'b000, bus.z_valid}, 4'd0);
    @(posedge clk);
    #1;
    chk("amr_held.gnt", bus.gnt, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b1111, 4'b0001, 2'd0, 1'b1, "amr_after");

`ifdef MUX4_ARB_LOCK_EN
    // Lock keeps owner 0 past the burst cap; dropping it releases next edge.
    do_reset();
    bus.lock = 1'b1;
    for (int k = 0; k < 10; k++) step(4'b0011, 4'b0001, 2'd0, 1'b1, $sformatf("lock%0d", k));
    bus.lock = 1'b0;
    step(4'b0011, 4'b0010, 2'd1, 1'b1, "lock_drop");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
